axi_mem_slave: RTL and testbench

AXI4 memory responder serving the load/store traffic issued by the core's exec stage. It presents the 512-bit data, 29-bit address, 4-bit ID AXI4 slave port the exec stage drives, and backs it with a word-organised on-chip RAM. Narrow transfers use the core's low-lane convention: data always occupies `rdata`/`wdata` bits [31:0]. It sits on the memory side of the core-to-memory interconnect, or directly on the exec stage port in simulation.

---
 rtl/axi_mem_slave_if.sv | 59 +++++
 rtl/axi_mem_slave.sv | 174 +++++++++++++++++
 tb/tb_axi_mem_slave.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_slave_if.sv
// axi_mem_slave_if: AXI4 slave port bundle (512b data, 29b addr, 4b id).
// The exec-stage side takes the master view; the memory takes the slave view.
interface axi_mem_slave_if;
  logic [28:0]  araddr;
  logic [1:0]   arburst;
  logic [3:0]   arid;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic         arvalid;
  logic         arready;
  logic [511:0] rdata;
  logic [3:0]   rid;
  logic         rlast;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [28:0]  awaddr;
  logic [1:0]   awburst;
  logic [3:0]   awid;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic         awvalid;
  logic         awready;
  logic [511:0] wdata;
  logic [63:0]  wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;

  modport slave (
    input  araddr, arburst, arid, arlen, arsize, arvalid,
    output arready,
    output rdata, rid, rlast, rresp, rvalid,
    input  rready,
    input  awaddr, awburst, awid, awlen, awsize, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output araddr, arburst, arid, arlen, arsize, arvalid,
    input  arready,
    input  rdata, rid, rlast, rresp, rvalid,
    output rready,
    output awaddr, awburst, awid, awlen, awsize, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );
endinterface

// File: rtl/axi_mem_slave.sv
// axi_mem_slave: AXI4 responder over a word RAM, one transaction at a time.
// Narrow transfers ride data bits [31:0]; upper data bits read as zero.
module axi_mem_slave #(
  parameter int MEM_WORDS = 65536
) (
  input  logic clk,
  input  logic rstn,
  axi_mem_slave_if.slave bus
);
  localparam int IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [2:0] {
    IDLE, WDATA, BRESP, RMEM, RDATA
  } state_t;

  typedef struct packed {
    logic [28:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } req_t;

  state_t      state;
  req_t        q;
  logic [7:0]  cnt;
  logic        bdec;
  logic        bslv;

  logic [31:0] mem [MEM_WORDS];

  logic [26:0] widx;
  logic [IW-1:0] ridx;
  logic        dec;
  logic        slv;
  logic        last;
  logic        wr;
  logic        dec_all;
  logic        slv_all;
  logic [28:0] naddr;
  logic [31:0] rword;
  logic [31:0] rbeat;
  logic [1:0]  beat_resp;

  assign widx = q.addr[28:2];
  assign ridx = widx[IW-1:0];
  assign dec  = 32'(widx) >= 32'(MEM_WORDS);
  assign slv  = !(q.size == 3'd2 || q.size == 3'd0) || q.burst[1];
  assign last = cnt == q.len;
  assign wr   = bus.wvalid && bus.wready;
  assign rword = mem[ridx];

  assign beat_resp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);

  // wlast is only checked against the beat count, never used to end a burst
  assign dec_all = bdec | dec;
  assign slv_all = bslv | slv | (bus.wlast != last);

  assign bus.awready = state == IDLE;
  assign bus.arready = (state == IDLE) && !bus.awvalid;

  always_comb begin
    naddr = q.addr;
    if (q.burst == 2'b01)
      naddr = q.addr + (29'd1 << q.size);
  end

  always_comb begin
    rbeat = 32'd0;
    if (!dec && !slv) begin
      if (q.size == 3'd0)
        rbeat = {24'd0, rword[{q.addr[1:0], 3'b000} +: 8]};
      else
        rbeat = rword;
    end
  end

  // RAM has no reset; a handshaked beat stays written across reset
  always_ff @(posedge clk) begin
    if (wr && !dec && !slv) begin
      if (q.size == 3'd0) begin
        if (bus.wstrb[0])
          mem[ridx][{q.addr[1:0], 3'b000} +: 8] <= bus.wdata[7:0];
      end else begin
        for (int k = 0; k < 4; k++)
          if (bus.wstrb[k])
            mem[ridx][8*k +: 8] <= bus.wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      q          <= '0;
      cnt        <= '0;
      bdec       <= 1'b0;
      bslv       <= 1'b0;
      bus.wready <= 1'b0;
      bus.rvalid <= 1'b0;
      bus.rlast  <= 1'b0;
      bus.rdata  <= '0;
      bus.rresp  <= 2'b00;
      bus.rid    <= '0;
      bus.bvalid <= 1'b0;
      bus.bresp  <= 2'b00;
      bus.bid    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.awvalid) begin
            q          <= '{bus.awaddr, bus.awid, bus.awlen,
                            bus.awsize, bus.awburst};
            cnt        <= '0;
            bdec       <= 1'b0;
            bslv       <= 1'b0;
            bus.wready <= 1'b1;
            state      <= WDATA;
          end else if (bus.arvalid) begin
            q     <= '{bus.araddr, bus.arid, bus.arlen,
                       bus.arsize, bus.arburst};
            cnt   <= '0;
            state <= RMEM;
          end
        end
        WDATA: begin
          if (bus.wvalid) begin
            bdec <= dec_all;
            bslv <= slv_all;
            if (last) begin
              bus.wready <= 1'b0;
              bus.bvalid <= 1'b1;
              bus.bid    <= q.id;
              bus.bresp  <= dec_all ? 2'b11 :
                            (slv_all ? 2'b10 : 2'b00);
              state      <= BRESP;
            end else begin
              cnt    <= cnt + 8'd1;
              q.addr <= naddr;
            end
          end
        end
        BRESP: begin
          if (bus.bready) begin
            bus.bvalid <= 1'b0;
            state      <= IDLE;
          end
        end
        RMEM: begin
          bus.rdata  <= {480'd0, rbeat};
          bus.rresp  <= beat_resp;
          bus.rid    <= q.id;
          bus.rlast  <= last;
          bus.rvalid <= 1'b1;
          state      <= RDATA;
        end
        RDATA: begin
          if (bus.rready) begin
            bus.rvalid <= 1'b0;
            if (last) begin
              bus.rlast <= 1'b0;
              state     <= IDLE;
            end else begin
              cnt    <= cnt + 8'd1;
              q.addr <= naddr;
              state  <= RMEM;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_mem_slave.sv
// tb_axi_mem_slave: directed AXI traffic with a queue-based scoreboard.
// Drivers push expected R/B beats; a negedge monitor pops and compares.
module tb_axi_mem_slave;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  axi_mem_slave_if bus ();

  axi_mem_slave #(.MEM_WORDS(65536)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] d;
    logic [3:0]  id;
    logic        last;
    logic [1:0]  resp;
  } rexp_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  rexp_t rq [$];
  bexp_t bq [$];
  rexp_t re;
  bexp_t be;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [511:0] act,
                     input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got no handshake expected one within 50 cycles", nm);
  endtask

  initial forever begin
    @(negedge clk);
    if (rstn) begin
      if (bus.rvalid && bus.rready) begin
        if (rq.size() == 0) begin
          tmo("r_unexpected_beat");
        end else begin
          re = rq.pop_front();
          chk("r_data", bus.rdata, {480'd0, re.d});
          chk("r_id", 512'(bus.rid), 512'(re.id));
          chk("r_last", 512'(bus.rlast), 512'(re.last));
          chk("r_resp", 512'(bus.rresp), 512'(re.resp));
        end
      end
      if (bus.bvalid && bus.bready) begin
        if (bq.size() == 0) begin
          tmo("b_unexpected_resp");
        end else begin
          be = bq.pop_front();
          chk("b_id", 512'(bus.bid), 512'(be.id));
          chk("b_resp", 512'(bus.bresp), 512'(be.resp));
        end
      end
    end
  end

  task automatic do_write(
    input logic [28:0] a, input logic [3:0] id,
    input logic [2:0] sz, input logic [1:0] bu,
    input logic [7:0] len,
    input logic [31:0] d0, input logic [31:0] d1,
    input logic [31:0] d2, input logic [31:0] d3,
    input logic [63:0] strb, input int bad,
    input logic [1:0] bexp, input bit chk_ar,
    output int t_aw, output int t_b);
    logic [31:0] d [4];
    int n;
    d = '{d0, d1, d2, d3};
    t_aw = -1;
    t_b = -1;
    bq.push_back('{id, bexp});
    bus.awaddr  = a;
    bus.awid    = id;
    bus.awsize  = sz;
    bus.awburst = bu;
    bus.awlen   = len;
    bus.awvalid = 1'b1;
    bus.wdata   = {480'd0, d[0]};
    bus.wstrb   = strb;
    bus.wlast   = (len == 8'd0) ^ (bad == 0);
    bus.wvalid  = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!bus.awready && n < 50);
    if (!bus.awready) begin tmo("aw_accept"); return; end
    t_aw = cyc;
    if (chk_ar) chk("ar_blocked_by_aw", 512'(bus.arready), 512'd0);
    @(posedge clk);
    #1 bus.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.wdata  = {480'd0, d[i]};
      bus.wlast  = (i == int'(len)) ^ (i == bad);
      bus.wvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end
      while (!bus.wready && n < 50);
      if (!bus.wready) begin tmo("w_accept"); return; end
      @(posedge clk);
      #1;
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!bus.bvalid && n < 50);
    if (!bus.bvalid) begin tmo("b_valid"); return; end
    t_b = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(
    input logic [28:0] a, input logic [3:0] id,
    input logic [2:0] sz, input logic [1:0] bu,
    input logic [7:0] len,
    input logic [31:0] d0, input logic [31:0] d1,
    input logic [31:0] d2, input logic [31:0] d3,
    input logic [1:0] resp, input int hold,
    output int t_ar);
    logic [31:0] d [4];
    int n;
    int prev;
    d = '{d0, d1, d2, d3};
    t_ar = -1;
    for (int i = 0; i <= int'(len); i++)
      rq.push_back('{d[i], id, i == int'(len), resp});
    bus.araddr  = a;
    bus.arid    = id;
    bus.arsize  = sz;
    bus.arburst = bu;
    bus.arlen   = len;
    bus.arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!bus.arready && n < 50);
    if (!bus.arready) begin tmo("ar_accept"); return; end
    t_ar = cyc;
    prev = cyc;
    @(posedge clk);
    #1 bus.arvalid = 1'b0;
    bus.rready = (hold != 0);
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      do begin @(negedge clk); n++; end
      while (!bus.rvalid && n < 50);
      if (!bus.rvalid) begin
        tmo("r_valid");
        bus.rready = 1'b1;
        return;
      end
      chk("r_beat_latency", 512'(cyc - prev), 512'd2);
      if (i == hold) begin
        for (int k = 0; k < 5; k++) begin
          chk("r_hold_valid", 512'(bus.rvalid), 512'd1);
          chk("r_hold_data", bus.rdata, {480'd0, d[i]});
          @(negedge clk);
        end
        @(posedge clk);
        #1 bus.rready = 1'b1;
        @(negedge clk);
      end
      prev = cyc;
      @(posedge clk);
      #1;
      if (i + 1 == hold) bus.rready = 1'b0;
    end
    bus.rready = 1'b1;
  endtask

  int ta, tb, tr, n;

  initial begin
    bus.arvalid = 1'b0; bus.araddr = '0; bus.arid = '0;
    bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.awvalid = 1'b0; bus.awaddr = '0; bus.awid = '0;
    bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    bus.wlast = 1'b0;
    bus.rready = 1'b1;
    bus.bready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_rvalid", 512'(bus.rvalid), 512'd0);
    chk("rst_bvalid", 512'(bus.bvalid), 512'd0);
    chk("rst_wready", 512'(bus.wready), 512'd0);
    chk("rst_rlast", 512'(bus.rlast), 512'd0);
    chk("rst_rdata", bus.rdata, 512'd0);
    chk("rst_rresp", 512'(bus.rresp), 512'd0);
    chk("rst_bresp", 512'(bus.bresp), 512'd0);
    chk("rst_rid", 512'(bus.rid), 512'd0);
    chk("rst_bid", 512'(bus.bid), 512'd0);
    chk("rst_awready", 512'(bus.awready), 512'd1);
    chk("rst_arready", 512'(bus.arready), 512'd1);
    bus.awvalid = 1'b1;
    #1 chk("rst_arready_aw", 512'(bus.arready), 512'd0);
    bus.awvalid = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;

    // word store then load
    do_write(29'h100, 4'd3, 3'd2, 2'b00, 8'd0,
             32'hDEADBEEF, 0, 0, 0, 64'hf, -1, 2'b00, 0, ta, tb);
    chk("sw_b_latency", 512'(tb - ta), 512'd2);
    do_read(29'h100, 4'd3, 3'd2, 2'b00, 8'd0,
            32'hDEADBEEF, 0, 0, 0, 2'b00, -1, tr);

    // byte store into a word, word and byte loads
    do_write(29'h100, 4'd1, 3'd2, 2'b01, 8'd0,
             32'h11223344, 0, 0, 0, 64'hf, -1, 2'b00, 0, ta, tb);
    do_write(29'h101, 4'd2, 3'd0, 2'b01, 8'd0,
             32'h0000005A, 0, 0, 0, 64'h1, -1, 2'b00, 0, ta, tb);
    do_read(29'h100, 4'd4, 3'd2, 2'b01, 8'd0,
            32'h11225A44, 0, 0, 0, 2'b00, -1, tr);
    do_read(29'h101, 4'd5, 3'd0, 2'b01, 8'd0,
            32'h0000005A, 0, 0, 0, 2'b00, -1, tr);

    // INCR burst, stall on the second read beat
    do_write(29'h200, 4'd6, 3'd2, 2'b01, 8'd3,
             32'd1, 32'd2, 32'd3, 32'd4, 64'hf, -1, 2'b00, 0, ta, tb);
    do_read(29'h200, 4'd7, 3'd2, 2'b01, 8'd3,
            32'd1, 32'd2, 32'd3, 32'd4, 2'b00, 1, tr);

    // simultaneous AW and AR: write first, read right after B
    bus.araddr  = 29'h400;
    bus.arid    = 4'd9;
    bus.arsize  = 3'd2;
    bus.arburst = 2'b01;
    bus.arlen   = 8'd0;
    bus.arvalid = 1'b1;
    do_write(29'h400, 4'd8, 3'd2, 2'b01, 8'd0,
             32'h0BADF00D, 0, 0, 0, 64'hf, -1, 2'b00, 1, ta, tb);
    do_read(29'h400, 4'd9, 3'd2, 2'b01, 8'd0,
            32'h0BADF00D, 0, 0, 0, 2'b00, -1, tr);
    chk("ar_after_b", 512'(tr - tb), 512'd1);

    // decode error at word index MEM_WORDS
    do_read(29'h40000, 4'd10, 3'd2, 2'b01, 8'd0,
            32'd0, 0, 0, 0, 2'b11, -1, tr);
    do_write(29'h40000, 4'd11, 3'd2, 2'b01, 8'd0,
             32'hFFFFFFFF, 0, 0, 0, 64'hf, -1, 2'b11, 0, ta, tb);

    // WRAP write is rejected and leaves RAM alone
    do_write(29'h300, 4'd12, 3'd2, 2'b01, 8'd0,
             32'h12345678, 0, 0, 0, 64'hf, -1, 2'b00, 0, ta, tb);
    do_write(29'h300, 4'd13, 3'd2, 2'b10, 8'd0,
             32'hCAFEF00D, 0, 0, 0, 64'hf, -1, 2'b10, 0, ta, tb);
    do_read(29'h300, 4'd14, 3'd2, 2'b01, 8'd0,
            32'h12345678, 0, 0, 0, 2'b00, -1, tr);

    // early wlast on a two-beat write
    do_write(29'h500, 4'd15, 3'd2, 2'b01, 8'd1,
             32'hA, 32'hB, 0, 0, 64'hf, 0, 2'b10, 0, ta, tb);

    // reset while a read beat is presented
    bus.rready  = 1'b0;
    bus.araddr  = 29'h100;
    bus.arid    = 4'd2;
    bus.arsize  = 3'd2;
    bus.arburst = 2'b01;
    bus.arlen   = 8'd0;
    bus.arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!bus.arready && n < 50);
    @(posedge clk);
    #1 bus.arvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!bus.rvalid && n < 50);
    chk("pre_rst_rvalid", 512'(bus.rvalid), 512'd1);
    #2 rstn = 1'b0;
    #1 chk("async_rst_rvalid", 512'(bus.rvalid), 512'd0);
    chk("async_rst_awready", 512'(bus.awready), 512'd1);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    bus.rready = 1'b1;
    do_read(29'h100, 4'd3, 3'd2, 2'b01, 8'd0,
            32'h11225A44, 0, 0, 0, 2'b00, -1, tr);

    repeat (3) @(negedge clk);
    chk("rq_drained", 512'(rq.size()), 512'd0);
    chk("bq_drained", 512'(bq.size()), 512'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish by 500us");
    $fatal(1);
  end
endmodule
